// File: rtl/exu_gpr_pkg.sv
// Shared types and sizing for the multi-port GPR; provides default widths when the core headers are absent.
`ifndef RV_GPR_AW
`define RV_GPR_AW 5
`endif
`ifndef RV_XLEN
`define RV_XLEN 32
`endif

package exu_gpr_pkg;
  typedef logic [`RV_GPR_AW-1:0] gpr_addr_t;
  typedef logic [`RV_XLEN-1:0]   gpr_data_t;

  localparam int GPR_NUM = 2**`RV_GPR_AW;
endpackage

// File: rtl/exu_gpr_wr_arb.sv
// Per-register write selector: highest-index matching port wins; multi flags a colliding write.
// Latency: combinational. Backpressure: none, lower-priority colliding writes are dropped.
module exu_gpr_wr_arb
  import exu_gpr_pkg::*;
#(
  parameter int WR_PORTS = 2,
  parameter int AW       = `RV_GPR_AW,
  parameter int XLEN     = `RV_XLEN,
  parameter int R        = 1
) (
  input  logic            wr_en   [WR_PORTS],
  input  logic [AW-1:0]   wr_addr [WR_PORTS],
  input  logic [XLEN-1:0] wr_data [WR_PORTS],
  output logic            hit,
  output logic [XLEN-1:0] data,
  output logic            multi
);

  always_comb begin
    hit   = 1'b0;
    data  = '0;
    multi = 1'b0;
    // Ascending scan so the last (highest-index) match overrides earlier ones.
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_en[p] && (wr_addr[p] == AW'(R))) begin
        multi = multi | hit;
        hit   = 1'b1;
        data  = wr_data[p];
      end
    end
  end

endmodule

// File: rtl/exu_gpr_mp.sv
// Multi-port GPR with per-register busy scoreboard; same-cycle forwarding under EXU_GPR_BYPASS_EN.
// Latency: reads combinational, writes/busy visible next cycle. Backpressure: none, issue stalls via rd_busy/rsv_ok.
module exu_gpr_mp
  import exu_gpr_pkg::*;
#(
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int AW       = `RV_GPR_AW,
  parameter int XLEN     = `RV_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rd_addr [RD_PORTS],
  output logic [XLEN-1:0] rd_data [RD_PORTS],
  output logic            rd_busy [RD_PORTS],
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rsv_ok,
  input  logic            wr_en   [WR_PORTS],
  input  logic [AW-1:0]   wr_addr [WR_PORTS],
  input  logic [XLEN-1:0] wr_data [WR_PORTS],
  output logic            wr_conflict,
  output logic            err_sticky
);

  localparam int NUM = 1 << AW;

  logic [XLEN-1:0] regs [NUM];
  logic [XLEN-1:0] wdat [NUM];
  logic [NUM-1:0]  busy;
  logic [NUM-1:0]  hit;
  logic [NUM-1:0]  multi;
  logic [NUM-1:0]  set;

  // x0 has no arbiter, no scoreboard entry and no storage updates.
  assign hit[0]   = 1'b0;
  assign multi[0] = 1'b0;
  assign wdat[0]  = '0;
  assign set[0]   = 1'b0;

  for (genvar r = 1; r < NUM; r++) begin : g_arb
    exu_gpr_wr_arb #(
      .WR_PORTS (WR_PORTS),
      .AW       (AW),
      .XLEN     (XLEN),
      .R        (r)
    ) u_arb (
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (hit[r]),
      .data    (wdat[r]),
      .multi   (multi[r])
    );
    assign set[r] = rsv_en && (rsv_addr == AW'(r));
  end

  assign wr_conflict = |multi;
  assign rsv_ok      = rst || (rsv_addr == '0) || !busy[rsv_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM; r++) regs[r] <= '0;
      busy       <= '0;
      err_sticky <= 1'b0;
    end else begin
      for (int r = 1; r < NUM; r++) begin
        if (hit[r]) regs[r] <= wdat[r];
      end
      // A new reservation outranks the writeback of the older op to the same register.
      busy       <= set | (busy & ~hit);
      err_sticky <= err_sticky | wr_conflict | (rsv_en && !rsv_ok);
    end
  end

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_data[i] = '0;
      rd_busy[i] = 1'b0;
      if (!rst && (rd_addr[i] != '0)) begin
        rd_data[i] = regs[rd_addr[i]];
        rd_busy[i] = busy[rd_addr[i]];
`ifdef EXU_GPR_BYPASS_EN
        if (hit[rd_addr[i]]) begin
          rd_data[i] = wdat[rd_addr[i]];
          rd_busy[i] = busy[rd_addr[i]] && set[rd_addr[i]];
        end
`endif
      end
    end
  end

endmodule

// File: doc/exu_gpr_mp.md
# exu_gpr_mp

Multi-port general-purpose register file with a per-register scoreboard, the next-generation GPR for the execution unit. It serves RD_PORTS combinational reads and WR_PORTS same-cycle writes, with fixed write-port priority. It tracks in-flight long-latency destinations through busy bits so issue logic can stall on RAW hazards. It replaces the single-write-port GPR plus external channel mux.

## Interface
One clock; reset is synchronous and active-high.

Parameters:
- RD_PORTS, 2, number of read ports (1..4)
- WR_PORTS, 2, number of write ports (1..4); higher index has higher priority
- AW, `RV_GPR_AW, register address width; 2**AW registers
- XLEN, `RV_XLEN, register data width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- rd_addr[RD_PORTS]  in  AW  read addresses
- rd_data[RD_PORTS]  out  XLEN  read data, combinational
- rd_busy[RD_PORTS]  out  1  addressed register has a pending reservation
- rsv_en  in  1  reserve destination of an issuing long-latency op
- rsv_addr  in  AW  register to reserve
- rsv_ok  out  1  rsv_addr is free (combinational; 1 for x0)
- wr_en[WR_PORTS]  in  1  write enables
- wr_addr[WR_PORTS]  in  AW  write addresses
- wr_data[WR_PORTS]  in  XLEN  write data
- wr_conflict  out  1  two or more enabled ports target the same nonzero address this cycle (combinational)
- err_sticky  out  1  latched on wr_conflict or on rsv_en with rsv_ok=0; cleared only by rst

## Operation
- Storage: 2**AW x XLEN registers plus 2**AW busy bits. x0 reads 0 and is never written or reserved. Writes and reservations to x0 are ignored without error.
- Write: for each register r≠0, the highest-index port with wr_en and wr_addr==r supplies the next value. Lower-index colliding writes are dropped and wr_conflict is asserted.
- Busy set: rsv_en && rsv_addr≠0 sets busy[rsv_addr] at the edge.
- Busy clear: any enabled write to r clears busy[r] at the edge.
- Simultaneous set and clear on the same r: set wins, and busy stays 1. This means an older op writes back while a newer op reserves.
- Reserve when already busy: busy stays 1, err_sticky is set, and the reservation is not counted twice.
- Write to a non-busy register is legal (single-cycle path), and busy is unaffected.
- rd_busy[i] = busy[rd_addr[i]], with the bypass modification below.

## Timing
- Reads: 0-cycle combinational. Writes become visible on rd_data the cycle after wr_en, unless bypass is enabled.
- Busy: set/clear take effect the cycle after the event.
- Reset: all registers 0, all busy 0, err_sticky 0. Outputs during and after reset: rd_data=0, rd_busy=0, rsv_ok=1, wr_conflict driven by current inputs.
- Reset mid-operation: pending reservations are discarded. Writes in the reset cycle are ignored.
- err_sticky rises the cycle after the offending event.

## Configuration
- EXU_GPR_BYPASS_EN defined:
  - rd_data[i] returns the winning same-cycle wr_data when an enabled write port matches rd_addr[i]≠0.
  - rd_busy[i] reads 0 when a same-cycle write clears that register.
- Undefined: no forwarding. rd_data and rd_busy reflect only registered state.

## Structure
- Package exu_gpr_pkg:
  - typedefs gpr_addr_t (AW bits) and gpr_data_t (XLEN bits)
  - localparam GPR_NUM = 2**`RV_GPR_AW
- One sub-module exu_gpr_wr_arb. It is a per-register priority selector that takes wr_en/wr_addr/wr_data for index r and returns hit, data, and multi-hit. It is instantiated GPR_NUM-1 times. Its hit/data outputs are reused for the bypass path.

## Test plan
- Reset, then read x1..x31 → all 0, rd_busy=0, rsv_ok=1, err_sticky=0.
- Port0 writes x5=0x11 and port1 writes x5=0x22 in one cycle → wr_conflict=1 that cycle; next cycle x5 reads 0x22 and err_sticky=1.
- rsv x7, then 3 idle cycles, then write x7=0xAB → rd_busy=1 for 4 cycles, then 0 with rd_data=0xAB. In the same write cycle with EXU_GPR_BYPASS_EN: rd_data=0xAB and rd_busy=0.
- Write x7 and rsv x7 in the same cycle → next cycle x7 holds new data and busy=1.
- Write x0=0xFFFF_FFFF and rsv x0 → x0 reads 0, busy 0, no error.
- Reserve x3 twice without writeback → err_sticky=1. Then assert rst mid-stream → busy cleared, err_sticky=0, x3=0.
